// File: rtl/pbuf6_pkg.sv
// ---------------------------------------------------------------------------
// pbuf6_pkg : shared geometry and cell-index helper for the pbuf6 bank
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pbuf6_pkg;

   localparam int PBUF_ROWS = 3;
   localparam int PBUF_COLS = 2;
   localparam int PBUF_BITS = PBUF_ROWS * PBUF_COLS;

   function automatic int pbuf_bit_idx(input int row, input int col);
      return row * PBUF_COLS + col;
   endfunction

endpackage : pbuf6_pkg

`default_nettype wire

// File: rtl/pbuf6_store_3x2.sv
// ---------------------------------------------------------------------------
// pbuf_store_3x2 : 3-row x 2-column configuration store, column-strobed
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pbuf_store_3x2
   import pbuf6_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [PBUF_ROWS-1:0] dat,
   input  logic [PBUF_COLS-1:0] cap,
   output logic [PBUF_BITS-1:0] q
);

   logic [PBUF_BITS-1:0] cfg_q;
   logic [PBUF_BITS-1:0] cfg_d;

   // Each active column strobe loads every row of that column from the shared row lines.
   always_comb begin
      cfg_d = cfg_q;
      for (int r = 0; r < PBUF_ROWS; r++) begin
         for (int c = 0; c < PBUF_COLS; c++) begin
            if (cap[c]) begin
               cfg_d[pbuf_bit_idx(r, c)] = dat[r];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q <= '0;
      end else begin
         cfg_q <= cfg_d;
      end
   end

   assign q = cfg_q;

endmodule : pbuf_store_3x2

`default_nettype wire

// File: rtl/pbuf6.sv
// ---------------------------------------------------------------------------
// pbuf6 : six-bit programmable tri-state buffer bank
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pbuf6
   import pbuf6_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [PBUF_BITS-1:0] in,
   output wire  [PBUF_BITS-1:0] out,
   input  logic                 prog_dat0,
   input  logic                 prog_dat1,
   input  logic                 prog_dat2,
   input  logic                 prog_cap0,
   input  logic                 prog_cap1
);

   logic [PBUF_BITS-1:0] q;

   pbuf_store_3x2 u_store (
      .clk   (clk),
      .rst_n (rst_n),
      .dat   ({prog_dat2, prog_dat1, prog_dat0}),
      .cap   ({prog_cap1, prog_cap0}),
      .q     (q)
   );

   // Purely combinational path from in to out; a disabled bit never drives.
   genvar gi;
   generate
      for (gi = 0; gi < PBUF_BITS; gi++) begin : g_drv
         assign out[gi] = q[gi] ? in[gi] : 1'bz;
      end
   endgenerate

endmodule : pbuf6

`default_nettype wire

// File: tb/tb_pbuf6.sv
// ---------------------------------------------------------------------------
// tb_pbuf6 : directed self-checking bench for the pbuf6 buffer bank
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pbuf6;

   logic       clk;
   logic       rst_n;
   logic [5:0] din;
   wire  [5:0] dout;
   logic       dat0, dat1, dat2;
   logic       cap0, cap1;

   int n_tests;
   int n_fail;

   pbuf6 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (din),
      .out       (dout),
      .prog_dat0 (dat0),
      .prog_dat1 (dat1),
      .prog_dat2 (dat2),
      .prog_cap0 (cap0),
      .prog_cap1 (cap1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two bits per output: 0/1 for a driven level, 2 for high-Z.
   logic [11:0] out_code;
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_obs
         assign out_code[2*gi +: 2] = (dout[gi] === 1'bz) ? 2'd2 : {1'b0, dout[gi]};
      end
   endgenerate

   function automatic logic [11:0] exp_code(input logic [5:0] en, input logic [5:0] d);
      logic [11:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[2*i +: 2] = en[i] ? {1'b0, d[i]} : 2'd2;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic write_cols(input logic c0, input logic c1, input logic [2:0] d);
      @(negedge clk);
      {dat2, dat1, dat0} = d;
      cap0 = c0;
      cap1 = c1;
      @(posedge clk);
      #1;
      cap0 = 1'b0;
      cap1 = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [5:0] p;
      n_tests = 0;
      n_fail  = 0;
      rst_n = 1'b1;
      din   = '0;
      {dat2, dat1, dat0} = 3'b000;
      cap0 = 1'b0;
      cap1 = 1'b0;

      // Reset then explicit zero capture.
      #2 rst_n = 1'b0;
      #1;
      check("reset_q", {6'b0, dut.q}, 12'h000);
      do_reset();
      write_cols(1'b1, 1'b1, 3'b000);
      din = 6'b000000; #1;
      check("reset_out_in0", out_code, 12'hAAA);
      din = 6'b111111; #1;
      check("reset_out_in1", out_code, 12'hAAA);
      check("reset_q_after_cap", {6'b0, dut.q}, 12'h000);

      // One buffer enabled at a time.
      for (int i = 0; i < 6; i++) begin
         p = 6'b1 << i;
         write_cols(1'b1, 1'b0, {p[4], p[2], p[0]});
         write_cols(1'b0, 1'b1, {p[5], p[3], p[1]});
         check($sformatf("bit%0d_q", i), {6'b0, dut.q}, {6'b0, p});
         din = 6'b000000; #1;
         check($sformatf("bit%0d_out0", i), out_code, exp_code(p, din));
         din = 6'b111111; #1;
         check($sformatf("bit%0d_out1", i), out_code, exp_code(p, din));
      end

      // Column isolation.
      do_reset();
      write_cols(1'b1, 1'b0, 3'b111);
      check("iso_col0_q", {6'b0, dut.q}, {6'b0, 6'b010101});
      write_cols(1'b0, 1'b1, 3'b111);
      check("iso_col1_q", {6'b0, dut.q}, {6'b0, 6'b111111});
      write_cols(1'b1, 1'b0, 3'b000);
      check("iso_clr0_q", {6'b0, dut.q}, {6'b0, 6'b101010});
      din = 6'b110011; #1;
      check("iso_out", out_code, exp_code(6'b101010, 6'b110011));

      // Both strobes on one edge: dat2..0 = 1,0,1.
      write_cols(1'b1, 1'b1, 3'b101);
      check("both_q", {6'b0, dut.q}, {6'b0, 6'b110011});
      din = 6'b101010; #1;
      check("both_out", out_code, exp_code(6'b110011, 6'b101010));

      // Held strobe reloads idempotently.
      @(negedge clk);
      {dat2, dat1, dat0} = 3'b011;
      cap1 = 1'b1;
      repeat (3) @(posedge clk);
      #1 cap1 = 1'b0;
      check("held_q", {6'b0, dut.q}, {6'b0, 6'b011011});

      // Asynchronous reset between edges, with a capture pending.
      write_cols(1'b1, 1'b1, 3'b111);
      din = 6'b101010; #1;
      check("pre_rst_out", out_code, exp_code(6'b111111, 6'b101010));
      @(negedge clk);
      {dat2, dat1, dat0} = 3'b111;
      cap0 = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("async_q", {6'b0, dut.q}, 12'h000);
      check("async_out", out_code, 12'hAAA);
      @(posedge clk); #1;
      check("rst_hold_q", {6'b0, dut.q}, 12'h000);
      cap0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Final isolation.
      din = 6'b000000; #1;
      check("final_out0", out_code, 12'hAAA);
      din = 6'b111111; #1;
      check("final_out1", out_code, 12'hAAA);
      din = 6'b101010; #1;
      check("final_out2", out_code, 12'hAAA);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pbuf6

`default_nettype wire

// File: doc/pbuf6.md
Name: pbuf6

Overview:
- Six-bit programmable tri-state buffer bank.
- Each bit i drives out[i] = in[i] when its configuration bit q[i] is 1. Otherwise out[i] is high-Z.
- The configuration bits sit in a 3-row x 2-column store. The store is written one column at a time through three row data lines and two column capture strobes.
- Used as a configurable routing/isolation element in the programmable fabric.

Parameters:
- None. Width is fixed at 6 bits: 3 rows x 2 columns.

Ports:
- clk  input  1  system clock; all configuration storage is clocked on its rising edge
- rst_n  input  1  asynchronous active-low reset
- in  input  6  buffer data inputs
- out  output  6  tri-state buffer outputs
- prog_dat0  input  1  configuration data for row 0
- prog_dat1  input  1  configuration data for row 1
- prog_dat2  input  1  configuration data for row 2
- prog_cap0  input  1  capture strobe for column 0 (q0, q2, q4)
- prog_cap1  input  1  capture strobe for column 1 (q1, q3, q5)

Behaviour:
- Internal configuration vector q[5:0] must exist under exactly this name, so benches can probe it hierarchically.
- Cell map (row, column):
  - q0 = (0,0), q1 = (0,1)
  - q2 = (1,0), q3 = (1,1)
  - q4 = (2,0), q5 = (2,1)
- Row r data source is prog_dat{r}.
- Reset: rst_n low asynchronously clears q to 6'b000000. All outputs are then high-Z, regardless of in. q stays at zero while rst_n is low.
- Column 0 write: on a clk rising edge with prog_cap0 = 1, load q0 <= prog_dat0, q2 <= prog_dat1, q4 <= prog_dat2.
- Column 1 write: on a clk rising edge with prog_cap1 = 1, load q1 <= prog_dat0, q3 <= prog_dat1, q5 <= prog_dat2.
- Both strobes high on the same edge: both columns load the same row data.
- Strobe low: that column holds its value.
- Write latency: new q is visible one edge after capture. The strobe is level-sampled. A strobe held high for N cycles reloads on every edge, which is idempotent for static data.
- Datapath: purely combinational, zero cycles. out[i] = q[i] ? in[i] : 1'bz. No clock dependency from in to out.
- Enabled buffer with in[i] = X drives X. A disabled buffer never drives any value.
- Reset asserted mid-programming: q clears immediately and the pending capture is discarded.
- No readback port. Configuration is observable only through out behaviour and the q probe.

Decomposition:
- Shared package: constants PBUF_ROWS = 3, PBUF_COLS = 2, PBUF_BITS = 6, plus a function mapping (row, col) to bit index = row*2 + col.
- One sub-module: pbuf_store_3x2.
  - Inputs: clk, rst_n, dat[2:0], cap[1:0].
  - Output: q[5:0].
  - Holds the configuration cells.
- The top level instantiates pbuf_store_3x2 and generates six tri-state drivers.

Test Plan:
- Reset: pulse rst_n low, then capture zeros into both columns. Apply in = 6'b000000, then 6'b111111. Required: out === 6'bzzzzzz in both cases, q = 000000.
- Per-bit enable: for i = 0..5, load pattern 1<<i by writing column 0 (dat = p[0], p[2], p[4]) then column 1 (dat = p[1], p[3], p[5]). Required: q = 1<<i and out[i] follows in[i] (0 then 1). Every other out bit stays z.
- Column isolation: load 6'b010101 via cap0 only, then pulse cap1 with dat = 1,1,1. Required: q = 6'b111111. Then pulse cap0 with dat = 0,0,0. Required: q = 6'b101010.
- Simultaneous strobes: prog_cap0 = prog_cap1 = 1 with dat = 1,0,1. Required: q = 6'b110011. With in = 6'b101010, out = 10zz10.
- Async reset mid-operation: with q = 111111 and in = 6'b101010, assert rst_n low between clock edges. Required: q = 0 and out = zzzzzz immediately, without waiting for a clock edge.
- Final isolation: after reset, apply in = 000000, 111111 and 101010. Required: out === zzzzzz for each.
